// File: rtl/spike_ingress_pkg.sv
// spike_ingress_pkg: shared types and constants for the spike ingress queue.
//   spike_pkt_t        packet layout {tag, axon_idx}
//   REG_*              register word offsets (byte address bits [3:2])
//   STATUS_* / CTRL_*  bit positions inside the STATUS and CTRL registers
//   pack_status()      assembles the STATUS read word
package spike_ingress_pkg;

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] axon_idx;
    } spike_pkt_t;

    localparam logic [1:0] REG_PUSH   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_OVFCNT = 2'd3;

    localparam int unsigned STATUS_EMPTY     = 0;
    localparam int unsigned STATUS_FULL      = 1;
    localparam int unsigned STATUS_OVF       = 2;
    localparam int unsigned STATUS_COUNT_LSB = 8;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVF = 1;

    function automatic logic [31:0] pack_status(input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [7:0] count);
        logic [31:0] s;
        s                           = '0;
        s[STATUS_EMPTY]             = empty;
        s[STATUS_FULL]              = full;
        s[STATUS_OVF]               = ovf;
        s[STATUS_COUNT_LSB +: 8]    = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        write wdata_i (ignored when full)
//   pop_i         advance past the head entry (ignored when empty)
//   flush_i       empty the FIFO; wins over a same-cycle push or pop
//   wdata_i       write data
//   rdata_o       head entry, 0 while empty
//   full_o        count == DEPTH
//   empty_o       count == 0
//   count_o       number of stored entries
module sync_fifo
    import spike_ingress_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    always_comb begin
        full_o  = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
        count_o = count_q;
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;
        // Gate the head so the output is 0 (not stale storage) when empty.
        rdata_o = empty_o ? '0 : mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (!push_ok && pop_ok) count_q <= count_q - CW'(1);
        end
    end

    // Storage has no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spike_ingress_queue.sv
// spike_ingress_queue: Wishbone-mapped spike packet FIFO feeding neuron_core.
//   clk, rst_n             clock, asynchronous active-low reset
//   wbs_cyc_i .. wbs_dat_i Wishbone slave inputs (16-byte window at BASE_ADDR)
//   wbs_ack_o, wbs_dat_o   registered one-cycle ack; read data valid only on ack
//   pkt_valid_o/ready_i    valid/ready stream to neuron_core
//   pkt_data_o             head packet {tag, axon_idx}, first-word fall-through
//   ovf_irq_o              level interrupt: sticky overflow flag
// Registers: 0x0 PUSH(W), 0x4 STATUS(R), 0x8 CTRL(W: flush, clear ovf), 0xC drop counter.
// Build option: define SPIKE_INGRESS_OVF_CNT_EN to add the 16-bit saturating drop counter
// at 0xC; without it 0xC reads 0.
module spike_ingress_queue
    import spike_ingress_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PKT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             pkt_valid_o,
    output logic [PKT_W-1:0] pkt_data_o,
    input  logic             pkt_ready_i,
    output logic             ovf_irq_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          hit, ack_q, ack_d;
    logic          wr_en, rd_en, ctrl_wr;
    logic [1:0]    offset;
    logic          push_req, pop, flush, clr_ovf, drop;
    logic          ovf_q, ovf_d;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:PKT_W]};

    always_comb begin
        offset  = wbs_adr_i[3:2];
        hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        ack_d   = hit & ~ack_q;
        // All side effects are qualified by the registered ack, so each access acts once.
        wr_en   = ack_q & wbs_we_i;
        rd_en   = ack_q & ~wbs_we_i;
        ctrl_wr = wr_en & (offset == REG_CTRL);
        push_req = wr_en & (offset == REG_PUSH) & (wbs_sel_i[1:0] == 2'b11);
        flush    = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
        clr_ovf  = ctrl_wr & wbs_dat_i[CTRL_CLR_OVF];
        pop      = ~fifo_empty & pkt_ready_i;
        // Fullness is the pre-cycle state: a same-cycle pop does not make room.
        drop     = push_req & fifo_full & ~flush;
        ovf_d    = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            ovf_q <= ovf_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wbs_dat_i[PKT_W-1:0]),
        .rdata_o (pkt_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef SPIKE_INGRESS_OVF_CNT_EN
    logic [15:0] drop_cnt_q;
    logic        cnt_clr;

    assign cnt_clr = wr_en & (offset == REG_OVFCNT);

    // A clear wins over a coincident drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (cnt_clr) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (offset)
            REG_STATUS: rdata = pack_status(fifo_empty, fifo_full, ovf_q, 8'(fifo_count));
`ifdef SPIKE_INGRESS_OVF_CNT_EN
            REG_OVFCNT: rdata = {16'h0, drop_cnt_q};
`endif
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        wbs_ack_o   = ack_q;
        wbs_dat_o   = rd_en ? rdata : '0;
        pkt_valid_o = ~fifo_empty;
        ovf_irq_o   = ovf_q;
    end

endmodule

// File: tb/tb_spike_ingress_queue.sv
module tb_spike_ingress_queue;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        valid;
    logic [15:0] pdata;
    logic        ready = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_ingress_queue #(
        .DEPTH     (DEPTH),
        .PKT_W     (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .pkt_valid_o (valid),
        .pkt_data_o  (pdata),
        .pkt_ready_i (ready),
        .ovf_irq_o   (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a packet queue plus the flag/counter rules, advanced on each edge.
    logic [15:0] mq[$];
    logic        m_ack = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ack = 1'b0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            bit hit, full_pre, pop, push, flush, clr_ovf, clr_cnt, dropped;
            hit      = cyc && stb && ((adr >> 4) == (BASE >> 4));
            full_pre = (mq.size() == DEPTH);
            pop      = (mq.size() > 0) && ready;
            push = 0; flush = 0; clr_ovf = 0; clr_cnt = 0; dropped = 0;
            if (m_ack && we) begin
                case (adr[3:2])
                    2'd0: push = (sel[1:0] == 2'b11);
                    2'd2: begin flush = wdat[0]; clr_ovf = wdat[1]; end
                    2'd3: clr_cnt = 1;
                    default: ;
                endcase
            end
            if (flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    if (full_pre) dropped = 1;
                    else mq.push_back(wdat[15:0]);
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (clr_cnt) m_cnt = 0;
            else if (dropped && m_cnt < 65535) m_cnt++;
            m_ack = hit && !m_ack;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] exp_dat;
            exp_dat = 32'h0;
            if (m_ack && !we) begin
                case (adr[3:2])
                    2'd1: exp_dat = {16'h0, 8'(mq.size()), 5'b0, m_ovf,
                                     mq.size() == DEPTH, mq.size() == 0};
`ifdef SPIKE_INGRESS_OVF_CNT_EN
                    2'd3: exp_dat = 32'(m_cnt);
`endif
                    default: exp_dat = 32'h0;
                endcase
            end
            check("ack", {31'h0, ack}, {31'h0, m_ack});
            check("dat_o", rdat, exp_dat);
            check("pkt_valid", {31'h0, valid}, {31'h0, mq.size() > 0});
            check("pkt_data", {16'h0, pdata}, {16'h0, (mq.size() > 0) ? mq[0] : 16'h0});
            check("ovf_irq", {31'h0, irq}, {31'h0, m_ovf});
        end
    end

    task automatic xfer(input logic w, input logic [3:0] off, input logic [31:0] d,
                        input logic [3:0] s, input bit pop_on_ack, output logic [31:0] rd);
        bit got;
        got = 0;
        rd  = 32'h0;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = BASE | {28'h0, off}; wdat = d; sel = s;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                rd  = rdat;
                if (pop_on_ack) ready = 1;
            end
        end
        if (!got) check("ack_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
        if (pop_on_ack) ready = 0;
    endtask

    task automatic push(input logic [15:0] v);
        logic [31:0] rd;
        xfer(1, 4'h0, {16'h0, v}, 4'hF, 0, rd);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] rd;
        xfer(1, off, d, 4'hF, 0, rd);
    endtask

    task automatic rd_reg(input logic [3:0] off, output logic [31:0] rd);
        xfer(0, off, 32'h0, 4'hF, 0, rd);
    endtask

    task automatic drain_all();
        bit done;
        done = 0;
        @(posedge clk); #1;
        ready = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!valid) done = 1;
        end
        if (!done) check("drain_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        ready = 0;
    endtask

    logic [31:0] r;
    logic [3:0]  acks;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_pdata", {16'h0, pdata}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;

        // 1: status after reset; held strobe acks every other cycle; miss never acks
        rd_reg(4'h4, r);
        check("t1_status", r, 32'h0000_0001);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = BASE | 32'h4; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks[i] = ack;
        end
        check("t1_held_ack", {28'h0, acks}, 32'h0000_000A);
        @(posedge clk); #1;
        adr = BASE + 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks[i] = ack;
        end
        check("t1_miss_ack", {28'h0, acks}, 32'h0);
        @(posedge clk); #1;
        cyc = 0; stb = 0;

        // 2: two packets, partial-sel push ignored, consecutive drain
        push(16'h0A05);
        push(16'h0B06);
        xfer(1, 4'h0, 32'h0000_0C07, 4'h1, 0, r);
        rd_reg(4'h4, r);
        check("t2_status", r, 32'h0000_0200);
        rd_reg(4'h0, r);
        check("t2_push_reads0", r, 32'h0);
        @(posedge clk); #1;
        ready = 1;
        @(negedge clk);
        check("t2_pkt0", {15'h0, valid, pdata}, 32'h0001_0A05);
        @(negedge clk);
        check("t2_pkt1", {15'h0, valid, pdata}, 32'h0001_0B06);
        @(negedge clk);
        check("t2_empty", {31'h0, valid}, 32'h0);
        @(posedge clk); #1;
        ready = 0;

        // 3: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) push(16'h1100 + 16'(i));
        rd_reg(4'h4, r);
        check("t3_status", r, 32'h0000_1006);
        check("t3_irq", {31'h0, irq}, 32'h1);
        @(posedge clk); #1;
        ready = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t3_order", {15'h0, valid, pdata}, {15'h0, 1'b1, 16'h1100 + 16'(i)});
        end
        @(negedge clk);
        check("t3_drained", {31'h0, valid}, 32'h0);
        @(posedge clk); #1;
        ready = 0;
        wr(4'h8, 32'h2);
        check("t3_irq_clr", {31'h0, irq}, 32'h0);

        // 4: push while full coinciding with a pop is still dropped
        for (int i = 0; i < 16; i++) push(16'h2200 + 16'(i));
        xfer(1, 4'h0, 32'h0000_22FF, 4'hF, 1, r);
        rd_reg(4'h4, r);
        check("t4_status", r, 32'h0000_0F04);
        drain_all();

        // 5: flush beats a coincident pop; ovf untouched
        for (int i = 0; i < 3; i++) push(16'h3300 + 16'(i));
        xfer(1, 4'h8, 32'h1, 4'hF, 1, r);
        @(negedge clk);
        check("t5_valid", {31'h0, valid}, 32'h0);
        rd_reg(4'h4, r);
        check("t5_status", r, 32'h0000_0005);
        wr(4'h8, 32'h2);

        // 6: drop counter
        wr(4'hC, 32'h0);
        for (int i = 0; i < 19; i++) push(16'h4400 + 16'(i));
        rd_reg(4'hC, r);
`ifdef SPIKE_INGRESS_OVF_CNT_EN
        check("t6_cnt", r, 32'h0000_0003);
`else
        check("t6_cnt", r, 32'h0000_0000);
`endif
        wr(4'hC, 32'h0);
        rd_reg(4'hC, r);
        check("t6_cnt_clr", r, 32'h0);
        drain_all();
        wr(4'h8, 32'h2);

        // 7: reset mid-transaction drops ack and valid at once
        push(16'h5505);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = BASE | 32'h4;
        @(negedge clk);
        @(negedge clk);
        check("t7_ack_before", {31'h0, ack}, 32'h1);
        #2;
        rst_n = 0;
        #1;
        check("t7_ack", {31'h0, ack}, 32'h0);
        check("t7_valid", {31'h0, valid}, 32'h0);
        check("t7_irq", {31'h0, irq}, 32'h0);
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        rst_n = 1;
        rd_reg(4'h4, r);
        check("t7_status", r, 32'h0000_0001);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
